// File: rtl/instr_stream_sequencer.sv
// Timestep owner and prefetch buffer for the processor controller: feeds external
// words from a small FIFO and stalls the datapath through one advance strobe.
module instr_stream_sequencer #(
  parameter int unsigned DATA_W = 10,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DATA_W-1:0]        src_data,
  input  logic                     src_valid,
  output logic                     src_ready,
  input  logic                     run,
  input  logic                     flush,
  input  logic                     ext_req,
  input  logic                     clr_req,
  output logic [DATA_W-1:0]        ext_data,
  output logic [1:0]               timestep,
  output logic                     adv,
  output logic                     stall,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [CNT_W-1:0]         retired
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              empty;
  logic              full;
  logic              push;
  logic              pop;

  // Handshake and advance control are purely combinational so a stall releases
  // on the very cycle the awaited word becomes visible.
  assign empty     = (fifo_count == CW'(0));
  assign full      = (fifo_count == CW'(DEPTH));
  assign src_ready = !reset && !full && !flush;
  assign stall     = run && ext_req && empty;
  assign adv       = run && !stall && !flush;
  assign push      = src_valid && src_ready;
  assign pop       = adv && ext_req;
  assign ext_data  = empty ? DATA_W'(0) : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= src_data;
  end

  // FIFO pointers and occupancy; count only registers, so no fall-through.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      fifo_count <= fifo_count + CW'(1);
      else if (pop && !push) fifo_count <= fifo_count - CW'(1);
    end
  end

  // Timestep: flush wins, then end-of-instruction, then normal advance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)              timestep <= 2'd0;
    else if (flush)         timestep <= 2'd0;
    else if (adv && clr_req) timestep <= 2'd0;
    else if (adv)           timestep <= timestep + 2'd1;
  end

  // Retired-instruction count survives flush and wraps naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)               retired <= '0;
    else if (adv && clr_req) retired <= retired + CNT_W'(1);
  end

endmodule

// File: tb/tb_instr_stream_sequencer.sv
// Self-checking bench: directed scenarios plus random traffic compared each cycle
// against a queue-based reference model of the sequencer.
module tb_instr_stream_sequencer;

  localparam int unsigned DATA_W = 10;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned CNT_W  = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic [DATA_W-1:0] src_data;
  logic              src_valid;
  logic              src_ready;
  logic              run;
  logic              flush;
  logic              ext_req;
  logic              clr_req;
  logic [DATA_W-1:0] ext_data;
  logic [1:0]        timestep;
  logic              adv;
  logic              stall;
  logic [$clog2(DEPTH):0] fifo_count;
  logic [CNT_W-1:0]  retired;

  instr_stream_sequencer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .src_data(src_data), .src_valid(src_valid),
    .src_ready(src_ready), .run(run), .flush(flush), .ext_req(ext_req),
    .clr_req(clr_req), .ext_data(ext_data), .timestep(timestep), .adv(adv),
    .stall(stall), .fifo_count(fifo_count), .retired(retired)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [DATA_W-1:0] q[$];
  int                m_ts;
  logic [CNT_W-1:0]  m_ret;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ts  = 0;
    m_ret = '0;
  endtask

  // Called at posedge+1 with inputs already driven; checks, clocks, updates model.
  task automatic step();
    logic e_ready, e_stall, e_adv, e_push, e_pop;
    logic [DATA_W-1:0] e_data;
    #4;
    e_ready = !flush && (q.size() < DEPTH);
    e_stall = run && ext_req && (q.size() == 0);
    e_adv   = run && !e_stall && !flush;
    e_data  = (q.size() != 0) ? q[0] : '0;
    e_push  = src_valid && e_ready;
    e_pop   = e_adv && ext_req;
    check_eq("src_ready",  32'(src_ready),  32'(e_ready));
    check_eq("stall",      32'(stall),      32'(e_stall));
    check_eq("adv",        32'(adv),        32'(e_adv));
    check_eq("ext_data",   32'(ext_data),   32'(e_data));
    check_eq("timestep",   32'(timestep),   32'(m_ts));
    check_eq("fifo_count", 32'(fifo_count), 32'(q.size()));
    check_eq("retired",    32'(retired),    32'(m_ret));
    @(posedge clk);
    if (flush) begin
      q.delete();
      m_ts = 0;
    end else begin
      if (e_pop)  void'(q.pop_front());
      if (e_push) q.push_back(src_data);
      if (e_adv && clr_req) begin
        m_ts  = 0;
        m_ret = m_ret + CNT_W'(1);
      end else if (e_adv) begin
        m_ts = (m_ts + 1) % 4;
      end
    end
    #1;
  endtask

  task automatic drive(input logic r, input logic v, input logic [DATA_W-1:0] d,
                       input logic e, input logic c, input logic f);
    run = r; src_valid = v; src_data = d; ext_req = e; clr_req = c; flush = f;
  endtask

  // Runs the current instruction to its ts3 end with no further bus use.
  task automatic finish_instr();
    for (int i = 0; i < 4 && m_ts != 3; i++) begin
      drive(1, 0, '0, 0, 0, 0);
      step();
    end
    drive(1, 0, '0, 0, 1, 0);
    step();
  endtask

  logic [CNT_W-1:0] ret_snap;

  initial begin
    drive(0, 0, '0, 0, 0, 0);
    reset = 1'b1;
    model_reset();
    #2;
    check_eq("rst_src_ready", 32'(src_ready), 32'(0));
    check_eq("rst_timestep",  32'(timestep),  32'(0));
    check_eq("rst_count",     32'(fifo_count), 32'(0));
    check_eq("rst_ext_data",  32'(ext_data),  32'(0));
    @(posedge clk); #1;
    reset = 1'b0;

    // 1: single ADD, fetched at ts0 and retired at ts3
    drive(1, 1, 10'h004, 1, 0, 0); step();
    drive(1, 0, '0, 1, 0, 0);      step();
    finish_instr();
    check_eq("t1_retired", 32'(retired), 32'(1));
    check_eq("t1_count",   32'(fifo_count), 32'(0));

    // 2: fetch stalls on empty FIFO until a word arrives
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, '0, 1, 0, 0); step();
    end
    drive(1, 1, 10'h041, 1, 0, 0); step();
    drive(1, 0, '0, 1, 0, 0);
    #1;
    check_eq("t2_stall_drop", 32'(stall),    32'(0));
    check_eq("t2_head",       32'(ext_data), 32'(10'h041));
    #(-0); step();
    check_eq("t2_ts", 32'(timestep), 32'(1));
    finish_instr();

    // 3: fill while halted; fifth word refused
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, DATA_W'(10'h100 + i), 0, 0, 0); step();
    end
    drive(0, 1, 10'h1ff, 0, 0, 0);
    check_eq("t3_ready_full", 32'(src_ready), 32'(0));
    check_eq("t3_count",      32'(fifo_count), 32'(4));
    check_eq("t3_ts",         32'(timestep),  32'(0));
    step();
    drive(0, 0, '0, 0, 0, 1); step();

    // 4: LOAD then its data word, instruction ends at ts1
    drive(0, 1, 10'h000, 0, 0, 0); step();
    drive(0, 1, 10'h155, 0, 0, 0); step();
    ret_snap = retired;
    drive(1, 0, '0, 1, 0, 0); step();
    drive(1, 0, '0, 1, 1, 0);
    check_eq("t4_data", 32'(ext_data), 32'(10'h155));
    step();
    check_eq("t4_ts",      32'(timestep), 32'(0));
    check_eq("t4_retired", 32'(retired),  32'(ret_snap + CNT_W'(1)));

    // 5: flush at ts2 with three words buffered drops the offered push
    drive(1, 1, 10'h011, 0, 0, 0); step();
    drive(1, 1, 10'h022, 0, 0, 0); step();
    drive(0, 1, 10'h033, 0, 0, 0); step();
    ret_snap = retired;
    drive(1, 1, 10'h3aa, 0, 0, 1); step();
    check_eq("t5_ts",      32'(timestep),   32'(0));
    check_eq("t5_count",   32'(fifo_count), 32'(0));
    check_eq("t5_retired", 32'(retired),    32'(ret_snap));

    // 6: asynchronous reset mid-instruction at ts3 with two words
    drive(1, 1, 10'h0a1, 0, 0, 0); step();
    drive(1, 1, 10'h0a2, 0, 0, 0); step();
    drive(1, 0, '0, 0, 0, 0);      step();
    #2 reset = 1'b1;
    #1;
    check_eq("t6_ts",        32'(timestep),   32'(0));
    check_eq("t6_count",     32'(fifo_count), 32'(0));
    check_eq("t6_retired",   32'(retired),    32'(0));
    check_eq("t6_ext_data",  32'(ext_data),   32'(0));
    check_eq("t6_src_ready", 32'(src_ready),  32'(0));
    model_reset();
    @(posedge clk); #1;
    check_eq("t6_ready_hold", 32'(src_ready), 32'(0));
    reset = 1'b0;

    // Random traffic with a loosely controller-like request pattern
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom % 8) != 0, $urandom % 2, DATA_W'($urandom),
            ($urandom % 3) == 0 || m_ts == 0, ($urandom % 4) == 0 || m_ts == 3,
            ($urandom % 64) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
